imem_fetch_resp: RTL
====================

# imem_fetch_resp

Instruction-memory responder for the fetch stage. It accepts word-aligned fetch addresses from the program-counter side over a valid/ready request channel. It reads a synchronous on-chip instruction array and returns the instruction, together with its address and fault flags, over a valid/ready response channel. A 2-entry response FIFO absorbs decode-side back-pressure, and a preload port fills the array before or between runs.

## Interface
- ADDRESS, 32, address width in bits
- DATA, 32, instruction width in bits
- DEPTH, 256, array size in 32-bit words (power of two, 16..4096)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  fetch request valid
- req_ready  out  1  responder can accept a request this cycle
- req_addr  in  ADDRESS  fetch byte address
- rsp_valid  out  1  response valid at FIFO head
- rsp_ready  in  1  consumer takes the response
- rsp_inst  out  DATA  instruction word
- rsp_addr  out  ADDRESS  byte address the response belongs to
- rsp_misaligned  out  1  req_addr[1:0] != 0
- rsp_oob  out  1  word index >= DEPTH
- ld_en  in  1  preload write strobe
- ld_addr  in  $clog2(DEPTH)  preload word index
- ld_data  in  DATA  preload word

## Operation
- A request is accepted when req_valid && req_ready.
- Word index is req_addr[ADDRESS-1:2].
- Read stage, one register stage:
  - Array read is synchronous.
  - Address and flags are captured alongside the read.
  - s1_valid marks an in-flight read.
- Fault handling:
  - If misaligned or out of range, rsp_inst = NOP (32'h0000_0013).
  - The matching flag is set.
  - The array is not indexed.
  - Both flags may be set together.
- Response FIFO:
  - 2 entries; each entry is {inst, addr, misaligned, oob}.
  - The s1 result is pushed unconditionally the cycle after acceptance.
- Flow control is credit based, so there is no overflow by construction:
  - occupancy = fifo_count + s1_valid
  - req_ready = (occupancy < 2) || (rsp_valid && rsp_ready && occupancy == 2)
- Responses come out in request order.
- Preload port:
  - ld_en writes ld_data to mem[ld_addr] at the clock edge.
  - It may be active at any time.
  - If the same cycle accepts a read of the same word, the read returns the old data (read-before-write).
- Array contents are not reset.

## Timing
- Reset values, asynchronous on rst low:
  - rsp_valid=0, rsp_inst=0, rsp_addr=0, rsp_misaligned=0, rsp_oob=0
  - FIFO count=0, s1_valid=0
  - req_ready=1 from the first cycle after reset release (combinational from empty state)
- Latency:
  - A request accepted at edge N lands in the FIFO at edge N+1.
  - rsp_valid is high in cycle N+1 when the FIFO was empty.
- Throughput: one request per cycle while rsp_ready is held high.
- Back-pressure: with rsp_ready low, at most 2 requests are accepted. req_ready then drops until a pop.
- Simultaneous push and pop with fifo_count==2 is legal. Count stays 2 and order is preserved.
- FIFO pointers are 1 bit and wrap naturally.
- Reset mid-operation drops the in-flight read and all FIFO entries. No response is produced for them.
- Outputs rsp_* are registered (FIFO head), with no combinational path from req_* to rsp_*.
- rsp_valid, once high, stays high with stable payload until rsp_ready.

## Structure
- Shared package fetch_pkg:
  - NOP_INST constant (32'h0000_0013)
  - fetch_rsp_t packed struct {inst, addr, misaligned, oob}
  - Helper for word index width ($clog2(DEPTH))
- Sub-module fetch_rsp_fifo: 2-entry synchronous FIFO of fetch_rsp_t with push/pop/count and async active-low reset.
- The top holds the array, the read stage and the credit logic.

## Test plan
- Preload mem[0..3] = 32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000013. Then request 0,4,8,12 back-to-back with rsp_ready=1. Expect responses one per cycle from cycle 1, in order, with flags 0.
- Hold rsp_ready=0 and drive req_valid continuously from addr 0. Expect exactly 2 accepts, then req_ready=0. Release rsp_ready. Expect responses for addr 0 then 4, and acceptance resuming the same cycle.
- Request addr 32'h6. Expect rsp_inst=32'h00000013, rsp_misaligned=1, rsp_oob=0, rsp_addr=32'h6.
- With DEPTH=256, request addr 32'h400. Expect NOP, rsp_oob=1. Request 32'h402. Expect both flags set.
- Same cycle: ld_en to word 2 with 32'hDEADBEEF and read of addr 8. Expect the old value. Read addr 8 again. Expect 32'hDEADBEEF.
- Assert rst low with 2 FIFO entries and 1 in-flight read. Expect rsp_valid=0 immediately and all rsp_* zero. After release, req_ready=1 and no stale response appears.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// The response entry travels through the FIFO as one packed word.
package fetch_pkg;

    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam int unsigned FETCH_ADDR_W = 32;
    localparam int unsigned FETCH_DATA_W = 32;

    typedef struct packed {
        logic [FETCH_DATA_W-1:0] inst;
        logic [FETCH_ADDR_W-1:0] addr;
        logic                    misaligned;
        logic                    oob;
    } fetch_rsp_t;

    localparam int unsigned RSP_W = $bits(fetch_rsp_t);

    function automatic int unsigned word_idx_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fetch_rsp_fifo.sv
// Two-entry synchronous FIFO of fetch responses; head is a registered entry.
// Push and pop in the same cycle are legal at any count, including full.
module fetch_rsp_fifo
    import fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [RSP_W-1:0] push_data,
    input  logic             pop,
    output logic [RSP_W-1:0] head,
    output logic [1:0]       count
);

    fetch_rsp_t ent_q [2];
    fetch_rsp_t ent_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_pop;

    always_comb begin
        ent_d[0] = ent_q[0];
        ent_d[1] = ent_q[1];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != 2'd0);
        // When full, wr_ptr equals rd_ptr: the slot being popped takes the new entry.
        if (push) begin
            ent_d[wr_ptr_q] = fetch_rsp_t'(push_data);
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            ent_q[0] <= ent_d[0];
            ent_q[1] <= ent_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = ent_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/imem_fetch_resp.sv
// Instruction-memory responder: synchronous array read, one read stage,
// and a 2-entry response FIFO guarded by credit-based request flow control.
module imem_fetch_resp
    import fetch_pkg::*;
#(
    parameter int unsigned ADDRESS = 32,
    parameter int unsigned DATA    = 32,
    parameter int unsigned DEPTH   = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDRESS-1:0]           req_addr,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA-1:0]              rsp_inst,
    output logic [ADDRESS-1:0]           rsp_addr,
    output logic                         rsp_misaligned,
    output logic                         rsp_oob,
    input  logic                         ld_en,
    input  logic [word_idx_w(DEPTH)-1:0] ld_addr,
    input  logic [DATA-1:0]              ld_data
);

    localparam int unsigned IDX_W = word_idx_w(DEPTH);

    logic [DATA-1:0]    mem_q [DEPTH];
    logic [DATA-1:0]    rdata_q;

    logic [IDX_W-1:0]   req_idx;
    logic               req_mis;
    logic               req_oob;
    logic               accept;
    logic               rd_en;

    logic               s1_valid_q, s1_valid_d;
    logic [ADDRESS-1:0] s1_addr_q, s1_addr_d;
    logic               s1_mis_q, s1_mis_d;
    logic               s1_oob_q, s1_oob_d;

    fetch_rsp_t         push_rsp;
    fetch_rsp_t         head_rsp;
    logic [RSP_W-1:0]   head_bits;
    logic [1:0]         fifo_count;
    logic [1:0]         occupancy;

    assign req_idx = req_addr[IDX_W+1:2];
    assign req_mis = |req_addr[1:0];
    assign req_oob = |req_addr[ADDRESS-1:IDX_W+2];
    assign accept  = req_valid && req_ready;
    assign rd_en   = accept && !req_mis && !req_oob;

    // Non-blocking read and write on the same edge give read-before-write.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_q[ld_addr] <= ld_data;
        end
        if (rd_en) begin
            rdata_q <= mem_q[req_idx];
        end
    end

    always_comb begin
        s1_valid_d = accept;
        s1_addr_d  = s1_addr_q;
        s1_mis_d   = s1_mis_q;
        s1_oob_d   = s1_oob_q;
        if (accept) begin
            s1_addr_d = req_addr;
            s1_mis_d  = req_mis;
            s1_oob_d  = req_oob;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_mis_q   <= 1'b0;
            s1_oob_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_addr_q  <= s1_addr_d;
            s1_mis_q   <= s1_mis_d;
            s1_oob_q   <= s1_oob_d;
        end
    end

    always_comb begin
        push_rsp.inst       = (s1_mis_q || s1_oob_q) ? NOP_INST : rdata_q;
        push_rsp.addr       = s1_addr_q;
        push_rsp.misaligned = s1_mis_q;
        push_rsp.oob        = s1_oob_q;
    end

    fetch_rsp_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s1_valid_q),
        .push_data (push_rsp),
        .pop       (rsp_ready),
        .head      (head_bits),
        .count     (fifo_count)
    );

    assign head_rsp       = fetch_rsp_t'(head_bits);
    assign rsp_valid      = (fifo_count != 2'd0);
    assign rsp_inst       = head_rsp.inst;
    assign rsp_addr       = head_rsp.addr;
    assign rsp_misaligned = head_rsp.misaligned;
    assign rsp_oob        = head_rsp.oob;

    // The in-flight read already owns a FIFO slot, so it counts as occupied.
    assign occupancy = fifo_count + {1'b0, s1_valid_q};
    assign req_ready = (occupancy < 2'd2) ||
                       (rsp_valid && rsp_ready && (occupancy == 2'd2));

endmodule
